wb_serial_master: RTL and testbench
===================================

WB_SERIAL_MASTER -- requirements
Module: wb_serial_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max bus-cycle wait before abort, 1..65535.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rx_data  input  8  command byte stream in.
REQ-005 SHALL have port rx_valid  input  1  rx_data valid.
REQ-006 SHALL have port rx_ready  output  1  byte accepted when rx_valid&rx_ready.
REQ-007 SHALL have port tx_data  output  8  response byte stream out.
REQ-008 SHALL have port tx_valid  output  1  tx_data valid.
REQ-009 SHALL have port tx_ready  input  1  byte consumed when tx_valid&tx_ready.
REQ-010 SHALL have port wb_adr_o  output  32  Wishbone byte address.
REQ-011 SHALL have port wb_dat_o  output  32  write data.
REQ-012 SHALL have port wb_dat_i  input  32  read data.
REQ-013 SHALL have port wb_we_o  output  1  write enable.
REQ-014 SHALL have port wb_sel_o  output  4  byte select, always 4'hF during cycle, 0 otherwise.
REQ-015 SHALL have port wb_stb_o  output  1  strobe.
REQ-016 SHALL have port wb_cyc_o  output  1  cycle; identical to wb_stb_o (classic, single transfer).
REQ-017 SHALL have port wb_ack_i  input  1  normal termination.
REQ-018 SHALL have port wb_err_i  input  1  error termination.
REQ-019 SHALL have port wb_rty_i  input  1  retry termination.

Function
REQ-020 SHALL implement states IDLE, ADDR, WDATA, BUS, RESP; rx_ready high only in IDLE, ADDR, WDATA.
REQ-021 SHALL in IDLE accept 8'h01 (read) or 8'h02 (write) -> ADDR, byte counter cleared; any other byte SHALL queue single response 8'hEF -> RESP.
REQ-022 SHALL in ADDR shift in 4 bytes, big-endian (first byte = adr[31:24]); after 4th: read -> BUS, write -> WDATA.
REQ-023 SHALL in WDATA shift in 4 bytes big-endian into wb_dat_o; after 4th -> BUS.
REQ-024 SHALL assert cyc/stb on the cycle after entering BUS and hold adr/dat/we/sel stable until termination.
REQ-025 SHALL terminate on first cycle with ack, err or rty high (priority err > rty > ack); cyc/stb SHALL drop the following cycle.
REQ-026 SHALL latch wb_dat_i on ack of a read.
REQ-027 SHALL count cycles in BUS; on reaching TIMEOUT with no termination, deassert cyc/stb and respond 8'hEE.
REQ-028 SHALL respond: read ack -> 8'h81 then 4 data bytes big-endian; write ack -> 8'h82; err -> 8'hEE; rty -> 8'hE0; timeout -> 8'hEE.
REQ-029 SHALL in RESP present bytes with tx_valid high, tx_data stable until tx_ready; last byte consumed -> IDLE.
REQ-030 SHALL tolerate tx_ready held low indefinitely (no byte loss, no timeout in RESP).
REQ-031 SHALL accept a new command byte no earlier than the cycle after final response byte consumed.
REQ-032 SHALL ignore ack/err/rty outside BUS.

Reset
REQ-033 SHALL on rst force IDLE next cycle from any state, including mid-bus-cycle (cyc/stb drop immediately, partial command discarded).
REQ-034 SHALL reset outputs: rx_ready=1 after reset, tx_valid=0, tx_data=0, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_sel_o=0, wb_adr_o=0, wb_dat_o=0.

Structure
REQ-035 SHALL place command/response codes (01, 02, 81, 82, EE, E0, EF) and state encoding in shared package.
REQ-036 SHALL be one flat module; no sub-modules.

Verification
REQ-037 SHALL test read: rx 01 00 00 80 04, responder acks after 2 cycles with 32'hDEADBEEF -> tx 81 DE AD BE EF; adr=32'h00008004, we=0.
REQ-038 SHALL test write: rx 02 00 00 00 10 12 34 56 78 -> one cycle adr=32'h10, dat=32'h12345678, sel=F, we=1; tx 82.
REQ-039 SHALL test error: write with wb_err_i on first stb cycle -> tx EE; cyc drops next cycle.
REQ-040 SHALL test timeout: TIMEOUT=8, read, no termination -> cyc drops after 8 cycles, tx EE.
REQ-041 SHALL test backpressure and bad opcode: tx_ready low 20 cycles during read response -> bytes unchanged, none lost; rx 7F -> tx EF.
REQ-042 SHALL test reset mid-cycle: rst during BUS -> cyc/stb low next cycle, no response, subsequent read succeeds.

Source files
------------

// File: rtl/wb_serial_master_pkg.sv
// wb_serial_master_pkg: command/response codes and FSM state encoding for the serial Wishbone master
package wb_serial_master_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS, RESP} state_t;
  localparam logic [7:0] CMD_RD  = 8'h01;
  localparam logic [7:0] CMD_WR  = 8'h02;
  localparam logic [7:0] RSP_RD  = 8'h81;
  localparam logic [7:0] RSP_WR  = 8'h82;
  localparam logic [7:0] RSP_ERR = 8'hEE;
  localparam logic [7:0] RSP_RTY = 8'hE0;
  localparam logic [7:0] RSP_BAD = 8'hEF;
endpackage

// File: rtl/wb_serial_master.sv
// wb_serial_master: byte-stream command decoder driving single classic Wishbone transfers
module wb_serial_master
  import wb_serial_master_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);
  state_t state, state_n;
  logic [1:0] bcnt;
  logic [15:0] tcnt;
  logic [39:0] resp, resp_n;
  logic [2:0] rlen;
  logic rx_fire, tx_fire, cmd_ok, term, tmo, rd_ack;
  logic [7:0] code;
  assign rx_ready = state == IDLE || state == ADDR || state == WDATA;
  assign tx_valid = state == RESP;
  assign tx_data  = resp[39:32];
  assign wb_stb_o = wb_cyc_o;
  assign wb_sel_o = {4{wb_cyc_o}};
  assign rx_fire  = rx_valid && rx_ready;
  assign tx_fire  = tx_valid && tx_ready;
  assign cmd_ok   = rx_data == CMD_RD || rx_data == CMD_WR;
  assign term     = wb_cyc_o && (wb_ack_i || wb_err_i || wb_rty_i);
  assign tmo      = wb_cyc_o && tcnt == 16'(TIMEOUT - 1);
  // a termination on the final allowed cycle wins over the timeout
  assign rd_ack   = wb_ack_i && !wb_err_i && !wb_rty_i && !wb_we_o;
  assign code     = wb_err_i ? RSP_ERR : wb_rty_i ? RSP_RTY :
                    wb_ack_i ? (wb_we_o ? RSP_WR : RSP_RD) : RSP_ERR;
  assign resp_n   = {code, rd_ack ? wb_dat_i : 32'h0};
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (rx_fire) state_n = cmd_ok ? ADDR : RESP;
      ADDR:    if (rx_fire && bcnt == 2'd3) state_n = wb_we_o ? WDATA : BUS;
      WDATA:   if (rx_fire && bcnt == 2'd3) state_n = BUS;
      BUS:     if (term || tmo) state_n = RESP;
      RESP:    if (tx_fire && rlen == 3'd1) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt     <= '0;
      tcnt     <= '0;
      resp     <= '0;
      rlen     <= '0;
      wb_cyc_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
    end else begin
      wb_cyc_o <= state_n == BUS;
      tcnt     <= wb_cyc_o ? tcnt + 16'd1 : 16'd0;
      if (rx_fire) bcnt <= state == IDLE ? 2'd0 : bcnt + 2'd1;
      if (rx_fire && state == IDLE) begin
        wb_we_o <= rx_data == CMD_WR;
        if (!cmd_ok) begin
          resp <= {RSP_BAD, 32'h0};
          rlen <= 3'd1;
        end
      end
      if (rx_fire && state == ADDR) wb_adr_o <= {wb_adr_o[23:0], rx_data};
      if (rx_fire && state == WDATA) wb_dat_o <= {wb_dat_o[23:0], rx_data};
      if (state == BUS && (term || tmo)) begin
        resp <= resp_n;
        rlen <= rd_ack ? 3'd5 : 3'd1;
      end
      if (tx_fire) begin
        resp <= resp << 8;
        rlen <= rlen - 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_wb_serial_master.sv
// tb_wb_serial_master: table-driven and randomized checks of wb_serial_master against a transaction-level model
module tb_wb_serial_master;
  localparam int TO = 8;
  localparam int K_NONE = 0, K_ACK = 1, K_ERR = 2, K_RTY = 3;
  logic clk = 0, rst = 1;
  logic [7:0] rx_data = 0, tx_data;
  logic rx_valid = 0, rx_ready, tx_valid, tx_ready = 0;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i, wb_err_i, wb_rty_i;
  logic [3:0] wb_sel_o;
  always #5 clk = ~clk;
  wb_serial_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );
  typedef struct {
    logic [7:0] op;
    logic [31:0] adr, dat, rdata;
    int kind, delay, hold;
    logic [7:0] exp;
  } vec_t;
  int compared = 0, mismatched = 0;
  int r_kind = K_NONE, r_delay = 0, k = 0, last_len = 0, cyc_total = 0;
  logic [31:0] r_rdata = 0, cap_adr = 0, cap_dat = 0;
  logic cap_we = 0, noise = 0, unstable = 0, stb_bad = 0, hit;
  logic [3:0] cap_sel = 0;
  logic [7:0] exp_q[$];
  vec_t tbl[9];
  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_dat_i = 0;
    forever begin
      @(negedge clk);
      if (wb_stb_o !== wb_cyc_o) stb_bad = 1;
      if (wb_cyc_o) begin
        k++;
        cyc_total++;
        if (k == 1) begin
          cap_adr = wb_adr_o; cap_dat = wb_dat_o; cap_we = wb_we_o; cap_sel = wb_sel_o;
        end else if ({wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o} !== {cap_adr, cap_dat, cap_we, cap_sel})
          unstable = 1;
        hit = r_kind != K_NONE && k == r_delay + 1;
        wb_ack_i = hit && r_kind == K_ACK;
        wb_err_i = hit && r_kind == K_ERR;
        wb_rty_i = hit && r_kind == K_RTY;
        wb_dat_i = hit ? r_rdata : $urandom;
      end else begin
        if (wb_sel_o !== 4'h0) stb_bad = 1;
        if (k != 0) last_len = k;
        k = 0;
        wb_ack_i = noise && ($urandom % 2 == 1);
        wb_err_i = noise && ($urandom % 2 == 1);
        wb_rty_i = noise && ($urandom % 2 == 1);
        wb_dat_i = $urandom;
      end
    end
  end
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data = b;
    rx_valid = 1;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) chk("rx_accept", rx_ready, 1);
    @(negedge clk);
    rx_valid = 0;
  endtask
  task automatic recv(input int hold, input bit rnd);
    int n = 0, got = 0;
    logic [7:0] first;
    logic moved = 0;
    tx_ready = 0;
    while (!tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("tx_valid_seen", tx_valid, 1);
    first = tx_data;
    repeat (hold) begin
      @(negedge clk);
      if (!tx_valid || tx_data !== first) moved = 1;
    end
    if (hold > 0) chk("bp_hold", moved, 0);
    while (got < exp_q.size() && n < 2000) begin
      tx_ready = rnd ? 1'($urandom % 2) : 1'b1;
      if (tx_valid && tx_ready) begin
        chk("tx_byte", tx_data, exp_q[got]);
        got++;
      end
      @(negedge clk);
      n++;
    end
    tx_ready = 0;
    chk("tx_count", got, exp_q.size());
    chk("idle_after_resp", {tx_valid, rx_ready}, 2'b01);
  endtask
  function automatic logic [7:0] code_of(vec_t v);
    if (v.kind == K_NONE || v.delay + 1 > TO) return 8'hEE;
    if (v.kind == K_ERR) return 8'hEE;
    if (v.kind == K_RTY) return 8'hE0;
    return v.op == 8'h01 ? 8'h81 : 8'h82;
  endfunction
  task automatic run_txn(input vec_t v, input bit rnd);
    logic [7:0] c = v.exp != 0 ? v.exp : code_of(v);
    int len = (v.kind != K_NONE && v.delay + 1 <= TO) ? v.delay + 1 : TO;
    exp_q = {};
    exp_q.push_back(c);
    if (c == 8'h81)
      for (int i = 3; i >= 0; i--) exp_q.push_back(v.rdata[i*8 +: 8]);
    r_kind = v.kind; r_delay = v.delay; r_rdata = v.rdata;
    unstable = 0; stb_bad = 0; last_len = 0;
    send_byte(v.op);
    for (int i = 3; i >= 0; i--) send_byte(v.adr[i*8 +: 8]);
    if (v.op == 8'h02)
      for (int i = 3; i >= 0; i--) send_byte(v.dat[i*8 +: 8]);
    recv(v.hold, rnd);
    chk("cyc_len", last_len, len);
    chk("adr", cap_adr, v.adr);
    chk("we", cap_we, v.op == 8'h02);
    chk("sel", cap_sel, 4'hF);
    if (v.op == 8'h02) chk("dat", cap_dat, v.dat);
    chk("bus_stable", unstable, 0);
    chk("stb_eq_cyc", stb_bad, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n, base;
    logic flag;
    vec_t v;
    tbl[0] = '{8'h01, 32'h00008004, 32'h0, 32'hDEADBEEF, K_ACK, 2, 0, 8'h81};
    tbl[1] = '{8'h02, 32'h00000010, 32'h12345678, 32'h0, K_ACK, 0, 0, 8'h82};
    tbl[2] = '{8'h02, 32'h00000020, 32'hA5A5A5A5, 32'h0, K_ERR, 0, 0, 8'hEE};
    tbl[3] = '{8'h01, 32'h00000040, 32'h0, 32'h0, K_NONE, 0, 0, 8'hEE};
    tbl[4] = '{8'h01, 32'h12345678, 32'h0, 32'hCAFEF00D, K_ACK, 1, 20, 8'h81};
    tbl[5] = '{8'h02, 32'hFFFFFFFC, 32'h0BADF00D, 32'h0, K_RTY, 3, 0, 8'hE0};
    tbl[6] = '{8'h01, 32'h80000000, 32'h0, 32'h01020304, K_ACK, 7, 0, 8'h81};
    tbl[7] = '{8'h02, 32'h00000100, 32'h55AA55AA, 32'h0, K_ACK, 8, 0, 8'hEE};
    tbl[8] = '{8'h01, 32'h00000200, 32'h0, 32'h11223344, K_ERR, 7, 3, 8'hEE};
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_tx", {tx_valid, tx_data}, 9'h0);
    chk("rst_wb_ctl", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, 7'h0);
    chk("rst_wb_adr_dat", {wb_adr_o, wb_dat_o}, 64'h0);
    for (int i = 0; i < 9; i++) run_txn(tbl[i], 0);
    base = cyc_total;
    exp_q = {8'hEF};
    send_byte(8'h7F);
    recv(4, 0);
    chk("bad_op_no_bus", cyc_total, base);
    r_kind = K_NONE;
    send_byte(8'h01);
    for (int i = 0; i < 4; i++) send_byte(8'h00);
    n = 0;
    while (!wb_cyc_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_cyc_seen", wb_cyc_o, 1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_bus", {wb_cyc_o, wb_stb_o}, 2'b00);
    chk("mid_rst_state", {tx_valid, rx_ready}, 2'b01);
    rst = 0;
    flag = 0;
    repeat (12) begin
      @(negedge clk);
      if (tx_valid || wb_cyc_o) flag = 1;
    end
    chk("mid_rst_silent", flag, 0);
    send_byte(8'h02);
    send_byte(8'hAA);
    rst = 1;
    @(negedge clk);
    rst = 0;
    run_txn(tbl[0], 0);
    noise = 1;
    for (int i = 0; i < 40; i++) begin
      v.op = ($urandom % 2 == 1) ? 8'h01 : 8'h02;
      v.adr = $urandom;
      v.dat = $urandom;
      v.rdata = $urandom;
      v.kind = ($urandom % 8 == 0) ? K_NONE : int'($urandom_range(1, 3));
      v.delay = $urandom_range(0, 9);
      v.hold = ($urandom % 3 == 0) ? int'($urandom_range(1, 5)) : 0;
      v.exp = 0;
      run_txn(v, 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
